// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed, double-buffered seven-segment scan driver with leading-zero blanking.
// Optional ghost-guard blanking at the start of each digit slot: define SEVSEG_GHOST_GUARD_EN.
module seven_seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
`ifdef SEVSEG_GHOST_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_active;
    logic [DIGITS-1:0]   r_active_dp;
    logic                r_pending;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_guard;
    logic                w_blank;
    logic [3:0]          w_nib;
    logic                w_dp_raw;
    logic [6:0]          w_seg_raw;
    logic [DIGITS-1:0]   w_an_raw;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_guard     = GUARD_EN && (r_cnt < CNT_W'(GUARD_CYCLES));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shadow captures every load; active changes only on a frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_active    <= '0;
            r_active_dp <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (load) begin
                r_shadow    <= data_in;
                r_shadow_dp <= dp_in;
            end
            if (w_frame_end) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_active    <= data_in;
                    r_active_dp <= dp_in;
                end else if (r_pending) begin
                    r_active    <= r_shadow;
                    r_active_dp <= r_shadow_dp;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_nib     = '0;
        w_dp_raw  = 1'b0;
        w_an_raw  = '0;
        w_blank   = blank_en && (r_idx != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_active[4*k +: 4];
                w_dp_raw    = r_active_dp[k];
                w_an_raw[k] = 1'b1;
            end
            if ((IDX_W'(k) >= r_idx) && (r_active[4*k +: 4] != 4'h0))
                w_blank = 1'b0;
        end
        w_seg_raw = w_blank ? 7'h00 : hex_font(w_nib);
        if (w_guard) begin
            w_seg_raw = 7'h00;
            w_dp_raw  = 1'b0;
            w_an_raw  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= {DIGITS{AN_INV}};
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg_raw ^ {7{SEG_INV}};
            dp         <= w_dp_raw ^ SEG_INV;
            an         <= w_an_raw ^ {DIGITS{AN_INV}};
            frame_done <= w_frame_end;
        end
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for a bank of DIGITS seven-segment digits that share one segment bus. Decodes hex nibbles 0-F with the team's standard active-high font. Scans one digit per SCAN_DIV clocks. Adds double-buffered loading (no mid-frame tearing), per-digit decimal points, leading-zero blanking and configurable output polarity. Sits between CPU-side display registers and board-level segment/anode pins.

Parameters:
DIGITS, 4, number of digits (1..8); digit 0 = data_in[3:0] = least significant
SCAN_DIV, 1000, clocks per digit slot (>=2)
SEG_ACTIVE_LOW, 0, 1 inverts seg and dp outputs
AN_ACTIVE_LOW, 1, 1 makes an[] active-low
GUARD_CYCLES, 2, ghost-guard blank length (used only with the optional feature; must be < SCAN_DIV)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
load  in  1  capture data_in/dp_in into shadow registers
data_in  in  4*DIGITS  hex nibbles
dp_in  in  DIGITS  decimal point per digit
blank_en  in  1  leading-zero blanking enable
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point of the selected digit
an  out  DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release): cnt=0, idx=0; shadow, active and pending=0; seg/dp inactive; an all inactive; frame_done=0.
- Scan counter cnt: width $clog2(SCAN_DIV); runs 0..SCAN_DIV-1 continuously.
- At terminal count: cnt<=0; idx advances modulo DIGITS (DIGITS-1 -> 0).
- Frame boundary = edge where cnt==SCAN_DIV-1 and idx==DIGITS-1. frame_done is registered and is high for the single cycle after that edge. Period is exactly DIGITS*SCAN_DIV cycles.
- Outputs are registered from the current idx and active registers. They lag idx by one cycle. Exactly one an bit is active outside reset.
- Load: when load=1, shadow<=data_in, shadow_dp<=dp_in, pending<=1. Several loads in one frame: last wins.
- Commit: at a frame-boundary edge with pending=1, active<=shadow and pending<=0.
- Load on a frame-boundary edge: data_in/dp_in bypass straight into active, and pending clears.
- Display contents never change mid-frame.
- Font (seg hex, active-high, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking: with blank_en=1, digit k>0 shows seg=00 when active nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked. dp is unaffected by blanking.
- blank_en is sampled live, not double-buffered.
- Polarity: seg/dp are XORed with SEG_ACTIVE_LOW. an is XORed with AN_ACTIVE_LOW. Inactive level follows polarity, including during reset.
- Reset mid-frame: everything returns to reset values immediately; any pending load is discarded.

Optional Feature:
SEVSEG_GHOST_GUARD_EN.
- Defined: for the first GUARD_CYCLES clocks of every digit slot (cnt<GUARD_CYCLES), an is all-inactive and seg/dp inactive. This suppresses ghosting during anode switching. Digit-slot timing and frame_done are unchanged.
- Undefined: no guard; an is active for the full slot; GUARD_CYCLES is ignored.

Test Plan:
1. Bench setup for all cases: DIGITS=4, SCAN_DIV=4, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0, feature off.
2. Reset held 0 -> an=4'hF, seg=00, dp=0, frame_done=0. Release -> an=4'hE one cycle after release, seg=3F.
3. load data_in=16'h12AF, dp_in=4'b0100, then run to commit -> per slot: an=E seg=71 dp=0; an=D seg=77 dp=0; an=B seg=5B dp=1; an=7 seg=06 dp=0.
4. Tearing: load 16'h3333 while idx=1 -> digits 1..3 keep old values through the current frame. New values appear only after the frame_done pulse.
5. data_in=16'h0050, blank_en=1 -> digit3 and digit2 seg=00, digit1 seg=6D, digit0 seg=3F. With blank_en=0 -> digit3 seg=3F.
6. Free-run 64 cycles -> frame_done pulses every 16 cycles, each exactly 1 cycle wide. Assert reset at cnt=2, idx=2 -> outputs inactive immediately; after release, scan restarts at digit 0.
